// File: rtl/hex_char_pkg.sv
// hex_char_pkg: shared constants for the two-bit character <-> seven-segment
// mapping ('d', 'E', '1', blank), the receiver FSM state enum and the
// decoder result payload. Also used by the transmit-side driver.
package hex_char_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned CODE_W  = 2;
  localparam int unsigned HIST_W  = 8;
  localparam int unsigned COUNT_W = 4;

  // Active-low patterns, bit0 = a ... bit6 = g
  localparam logic [SEG_W-1:0] PAT_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] PAT_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] PAT_ONE   = 7'b1111001;
  localparam logic [SEG_W-1:0] PAT_BLANK = 7'b1111111;

  localparam logic [CODE_W-1:0] CODE_D     = 2'b00;
  localparam logic [CODE_W-1:0] CODE_E     = 2'b01;
  localparam logic [CODE_W-1:0] CODE_ONE   = 2'b10;
  localparam logic [CODE_W-1:0] CODE_BLANK = 2'b11;

  typedef enum logic {
    ST_TRACK  = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              valid;
  } decode_t;

  // Code -> pattern, used by the transmit side
  function automatic logic [SEG_W-1:0] code_to_pat(input logic [CODE_W-1:0] code);
    case (code)
      CODE_D:   code_to_pat = PAT_D;
      CODE_E:   code_to_pat = PAT_E;
      CODE_ONE: code_to_pat = PAT_ONE;
      default:  code_to_pat = PAT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/hex_char_receiver_if.sv
// hex_char_receiver_if: segment-pattern input and decoded character outputs.
//   seg_in     : 7-bit active-low segment pattern (source -> receiver)
//   char_code  : last accepted valid code
//   char_valid : one-cycle pulse on valid acceptance
//   char_err   : one-cycle pulse on invalid acceptance
//   history    : last four accepted codes, newest in [1:0]
//   count      : accepted valid characters, modulo 16
// master = pattern source / checker side, slave = receiver.
interface hex_char_receiver_if;
  import hex_char_pkg::*;

  logic [SEG_W-1:0]   seg_in;
  logic [CODE_W-1:0]  char_code;
  logic               char_valid;
  logic               char_err;
  logic [HIST_W-1:0]  history;
  logic [COUNT_W-1:0] count;

  modport master (
    output seg_in,
    input  char_code, char_valid, char_err, history, count
  );

  modport slave (
    input  seg_in,
    output char_code, char_valid, char_err, history, count
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational pattern -> {code, valid} lookup.
//   pattern  : 7-bit active-low segment pattern
//   result_c : decoded code and valid flag (unrecognised -> valid = 0)
module seg7_pattern_decode
  import hex_char_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output decode_t          result_c
);

  always_comb begin
    result_c = '{code: CODE_BLANK, valid: 1'b0};
    case (pattern)
      PAT_D:     result_c = '{code: CODE_D,     valid: 1'b1};
      PAT_E:     result_c = '{code: CODE_E,     valid: 1'b1};
      PAT_ONE:   result_c = '{code: CODE_ONE,   valid: 1'b1};
      PAT_BLANK: result_c = '{code: CODE_BLANK, valid: 1'b1};
      default:   result_c = '{code: CODE_BLANK, valid: 1'b0};
    endcase
  end

endmodule

// File: rtl/hex_char_receiver.sv
// hex_char_receiver: samples an active-low 7-segment bus, waits for a pattern
// to hold STABLE_CYCLES sampled edges, then decodes each newly settled pattern
// into a 2-bit character code with history and acceptance count.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : hex_char_receiver_if.slave (seg_in in; char_* / history / count out)
module hex_char_receiver
  import hex_char_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  hex_char_receiver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SEG_W-1:0]   sample_q;
  logic [SEG_W-1:0]   cand_q,  cand_n;
  logic [SEG_W-1:0]   last_q,  last_n;
  logic [CNT_W-1:0]   cnt_q,   cnt_n;
  state_e             state_q, state_n;
  logic [CODE_W-1:0]  code_q,  code_n;
  logic [HIST_W-1:0]  hist_q,  hist_n;
  logic [COUNT_W-1:0] count_q, count_n;
  logic               valid_q, valid_n;
  logic               err_q,   err_n;
  logic               settle;
  decode_t            dec_c;

  // Decode the sampled pattern; on a settle it is always the candidate
  seg7_pattern_decode u_decode (
    .pattern  (sample_q),
    .result_c (dec_c)
  );

  // Input sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_q <= PAT_BLANK;
    else     sample_q <= bus.seg_in;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_TRACK;
      cand_q  <= PAT_BLANK;
      last_q  <= PAT_BLANK;
      cnt_q   <= '0;
      code_q  <= CODE_BLANK;
      hist_q  <= '1;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cand_q  <= cand_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      code_q  <= code_n;
      hist_q  <= hist_n;
      count_q <= count_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  // Stability tracking, acceptance and output update
  always_comb begin
    state_n = state_q;
    cand_n  = cand_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    code_n  = code_q;
    hist_n  = hist_q;
    count_n = count_q;
    valid_n = 1'b0;
    err_n   = 1'b0;
    settle  = 1'b0;

    case (state_q)
      ST_TRACK: begin
        if (sample_q == cand_q) begin
          cnt_n = cnt_q + CNT_W'(1);
        end else begin
          cand_n = sample_q;
          cnt_n  = CNT_W'(1);
        end
        settle = (cnt_n == CNT_W'(STABLE_CYCLES));
      end
      ST_LOCKED: begin
        // A change restarts at count 1; with STABLE_CYCLES = 1 that settles at once
        if (sample_q != last_q) begin
          state_n = ST_TRACK;
          cand_n  = sample_q;
          cnt_n   = CNT_W'(1);
          settle  = (cnt_n == CNT_W'(STABLE_CYCLES));
        end
      end
    endcase

    // Settled: accept only if different from the last accepted pattern
    if (settle) begin
      state_n = ST_LOCKED;
      if (cand_n != last_q) begin
        last_n = cand_n;
        if (dec_c.valid) begin
          code_n  = dec_c.code;
          hist_n  = {hist_q[HIST_W-CODE_W-1:0], dec_c.code};
          count_n = count_q + COUNT_W'(1);
          valid_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  assign bus.char_code  = code_q;
  assign bus.char_valid = valid_q;
  assign bus.char_err   = err_q;
  assign bus.history    = hist_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_hex_char_receiver.sv
// tb_hex_char_receiver: scoreboard bench for hex_char_receiver. Expected
// acceptance events are queued when a pattern is driven long enough to settle
// and compared when the receiver pulses char_valid / char_err.
module tb_hex_char_receiver;

  localparam int unsigned STABLE = 4;

  localparam logic [6:0] P_D     = 7'b0100001;
  localparam logic [6:0] P_E     = 7'b0000110;
  localparam logic [6:0] P_ONE   = 7'b1111001;
  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_BAD   = 7'h00;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [7:0] hist;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_char_receiver_if bus ();

  hex_char_receiver #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_obs;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] m_last;
  logic [1:0] m_code;
  logic [7:0] m_hist;
  logic [3:0] m_cnt;
  int         m_accepts;

  function automatic logic model_decode(input logic [6:0] p, output logic [1:0] c);
    c = 2'b11;
    case (p)
      7'b0100001: begin c = 2'b00; return 1'b1; end
      7'b0000110: begin c = 2'b01; return 1'b1; end
      7'b1111001: begin c = 2'b10; return 1'b1; end
      7'b1111111: begin c = 2'b11; return 1'b1; end
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_last    = P_BLANK;
    m_code    = 2'b11;
    m_hist    = 8'hFF;
    m_cnt     = 4'd0;
    m_accepts = 0;
    sb_q.delete();
  endtask

  // Pattern held long enough to settle: predict the resulting event, if any
  task automatic predict(input logic [6:0] p);
    logic [1:0] c;
    logic       ok;
    if (p != m_last) begin
      m_last = p;
      ok = model_decode(p, c);
      if (ok) begin
        m_code = c;
        m_hist = {m_hist[5:0], c};
        m_cnt  = m_cnt + 4'd1;
        m_accepts++;
        sb_q.push_back('{err: 1'b0, code: m_code, hist: m_hist, cnt: m_cnt});
      end else begin
        sb_q.push_back('{err: 1'b1, code: m_code, hist: m_hist, cnt: m_cnt});
      end
    end
  endtask

  // Entered #1 after an edge; pattern is sampled on exactly n edges
  task automatic hold(input logic [6:0] p, input int n);
    if (n >= int'(STABLE)) predict(p);
    bus.seg_in = p;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && (bus.char_valid || bus.char_err)) begin
      checks++;
      mon_obs = {bus.char_err, bus.char_code, bus.history, bus.count};
      if (bus.char_valid && bus.char_err) begin
        errors++;
        $display("FAIL event_exclusive: char_valid and char_err both high at %0t", $time);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got err=%0b code=%b hist=%h cnt=%0d at %0t",
                 mon_obs.err, mon_obs.code, mon_obs.hist, mon_obs.cnt, $time);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_obs !== mon_e)
          begin
            errors++;
            $display("FAIL event_payload: got err=%0b code=%b hist=%h cnt=%0d, want err=%0b code=%b hist=%h cnt=%0d",
                     mon_obs.err, mon_obs.code, mon_obs.hist, mon_obs.cnt,
                     mon_e.err, mon_e.code, mon_e.hist, mon_e.cnt);
          end
      end
    end
  end

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1;
    bus.seg_in = P_BLANK;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.char_code, bus.history, bus.count, bus.char_valid, bus.char_err};
    checks++;
    if (obs !== {2'b11, 8'hFF, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, {2'b11, 8'hFF, 4'h0, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    hold(P_BLANK, 20);
    obs = {bus.char_code, bus.history, bus.count, bus.char_valid, bus.char_err};
    checks++;
    if (obs !== {2'b11, 8'hFF, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL steady_blank: got %h want %h", obs, {2'b11, 8'hFF, 4'h0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_first_accept();
    logic [13:0] obs;
    predict(P_E);
    bus.seg_in = P_E;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.char_valid !== (i == int'(STABLE) + 1)) begin
        errors++;
        $display("FAIL first_accept_timing: edge %0d char_valid=%b want %b",
                 i, bus.char_valid, (i == int'(STABLE) + 1));
      end
    end
    hold(P_E, 4);
    obs = {bus.char_code, bus.history, bus.count};
    checks++;
    if (obs !== {2'b01, 8'hFD, 4'd1}) begin
      errors++;
      $display("FAIL first_accept_outputs: got %h want %h", obs, {2'b01, 8'hFD, 4'd1});
    end
  endtask

  task automatic test_glitch();
    logic [13:0] obs;
    hold(P_ONE, 2);
    hold(P_E, 8);
    obs = {bus.char_code, bus.history, bus.count};
    checks++;
    if (obs !== {2'b01, 8'hFD, 4'd1} || sb_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_silent: got %h want %h pending=%0d", obs, {2'b01, 8'hFD, 4'd1}, sb_q.size());
    end
  endtask

  task automatic test_sequence();
    logic [6:0] pats [4];
    int i;
    hold(P_D, 6);
    hold(P_ONE, 6);
    hold(P_E, 6);
    hold(P_D, 6);
    hold(P_ONE, 6);
    checks++;
    if (bus.history !== 8'b10_01_00_10 || bus.count !== 4'd6) begin
      errors++;
      $display("FAIL sequence_history: got hist=%h cnt=%0d want hist=%h cnt=6",
               bus.history, bus.count, 8'b10_01_00_10);
    end
    pats[0] = P_D; pats[1] = P_E; pats[2] = P_BLANK; pats[3] = P_ONE;
    i = 0;
    while (m_accepts < 17) begin
      hold(pats[i % 4], 5);
      i++;
    end
    hold(pats[(i + 3) % 4], 3);
    checks++;
    if (bus.count !== 4'd1 || bus.history !== m_hist || bus.char_code !== m_code) begin
      errors++;
      $display("FAIL count_wrap: got cnt=%0d hist=%h code=%b want cnt=1 hist=%h code=%b",
               bus.count, bus.history, bus.char_code, m_hist, m_code);
    end
  endtask

  task automatic test_back_to_back();
    hold(P_E, int'(STABLE));
    hold(P_ONE, int'(STABLE));
    hold(P_D, int'(STABLE));
    hold(P_BLANK, int'(STABLE));
    hold(P_BLANK, int'(STABLE));
    checks++;
    if ({bus.char_code, bus.history, bus.count} !== {m_code, m_hist, m_cnt} || sb_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got %h want %h pending=%0d",
               {bus.char_code, bus.history, bus.count}, {m_code, m_hist, m_cnt}, sb_q.size());
    end
  endtask

  task automatic test_invalid();
    logic [13:0] snap;
    snap = {m_code, m_hist, m_cnt};
    hold(P_BAD, int'(STABLE));
    hold(P_BAD, 4);
    checks++;
    if ({bus.char_code, bus.history, bus.count} !== snap || sb_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_accept: got %h want %h pending=%0d",
               {bus.char_code, bus.history, bus.count}, snap, sb_q.size());
    end
    hold(P_ONE, 2);
    hold(P_BAD, 6);
    checks++;
    if ({bus.char_code, bus.history, bus.count} !== snap || sb_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_rehold: got %h want %h pending=%0d",
               {bus.char_code, bus.history, bus.count}, snap, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs;
    bus.seg_in = P_D;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    obs = {bus.char_code, bus.history, bus.count, bus.char_valid, bus.char_err};
    checks++;
    if (obs !== {2'b11, 8'hFF, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", obs, {2'b11, 8'hFF, 4'h0, 1'b0, 1'b0});
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    predict(P_D);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.char_valid !== (i == int'(STABLE) + 1)) begin
        errors++;
        $display("FAIL reset_restart_timing: edge %0d char_valid=%b want %b",
                 i, bus.char_valid, (i == int'(STABLE) + 1));
      end
    end
    checks++;
    if ({bus.char_code, bus.history, bus.count} !== {2'b00, 8'hFC, 4'd1}) begin
      errors++;
      $display("FAIL reset_restart_outputs: got %h want %h",
               {bus.char_code, bus.history, bus.count}, {2'b00, 8'hFC, 4'd1});
    end
  endtask

  initial begin
    bus.seg_in = P_BLANK;
    model_reset();
    test_reset();
    test_first_accept();
    test_glitch();
    test_sequence();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
